// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave slice.
package spi_pkg;

   localparam int unsigned SPI_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      ACTIVE
   } spi_state_e;

   // {CPOL, CPHA}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin, with rise/fall detection
// on the synchronised level.
module spi_sync_edge #(
   parameter int unsigned STAGES  = 2,
   parameter bit          RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
      prev_d = sync_q[STAGES-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= {STAGES{RST_VAL}};
         prev_q <= RST_VAL;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign q    = sync_q[STAGES-1];
   assign rise = q & ~prev_q;
   assign fall = ~q & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI slave: oversampled SCLK/CS_n/MOSI, parallel RX word with valid pulse,
// held TX word with valid/ready. Define SPI_SLAVE_LSB_FIRST_EN for LSB-first words.
module spi_slave
   import spi_pkg::*;
#(
   parameter int unsigned        DATA_W      = SPI_DATA_W,
   parameter bit                 CPOL        = 1'b0,
   parameter bit                 CPHA        = 1'b0,
   parameter int unsigned        SYNC_STAGES = 2,
   parameter logic [DATA_W-1:0]  DEFAULT_TX  = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              cs_n,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              busy
);

   localparam int unsigned CNT_W    = $clog2(DATA_W + 1);
   localparam int unsigned SETTLE_W = $clog2(SYNC_STAGES + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

`ifdef SPI_SLAVE_LSB_FIRST_EN
   localparam int unsigned OUT_BIT = 0;
   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
      return w >> 1;
   endfunction
   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
      return {b, w[DATA_W-1:1]};
   endfunction
`else
   localparam int unsigned OUT_BIT = DATA_W - 1;
   function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
      return w << 1;
   endfunction
   function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
      return {w[DATA_W-2:0], b};
   endfunction
`endif

   logic sclk_s, sclk_rise, sclk_fall;
   logic cs_s, cs_fall, cs_rise_unused;
   logic mosi_s;
   logic [1:0] mosi_edge_unused;

   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
      .clk(clk), .rst(rst), .d(sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
   );
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .d(cs_n), .q(cs_s), .rise(cs_rise_unused), .fall(cs_fall)
   );
   spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .d(mosi), .q(mosi_s),
      .rise(mosi_edge_unused[0]), .fall(mosi_edge_unused[1])
   );

   logic lead_ev, trail_ev, sample_ev, shift_ev;
   assign lead_ev   = CPOL ? sclk_fall : sclk_rise;
   assign trail_ev  = CPOL ? sclk_rise : sclk_fall;
   assign sample_ev = CPHA ? trail_ev : lead_ev;
   assign shift_ev  = CPHA ? lead_ev : trail_ev;

   spi_state_e        state_q, state_d;
   logic [DATA_W-1:0] hold_q, hold_d;
   logic              hold_vld_q, hold_vld_d;
   logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
   logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              done_q, done_d;
   logic              drv_q, drv_d;
   logic              miso_q, miso_d;
   logic [DATA_W-1:0] rx_data_q, rx_data_d;
   logic              rx_valid_q, rx_valid_d;
   logic [SETTLE_W-1:0] settle_q, settle_d;
   logic              armed_q, armed_d;
   logic              settle_done, take_word;
   logic [DATA_W-1:0] load_word;

   assign settle_done = (settle_q == SETTLE_W'(SYNC_STAGES));

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      drv_d      = drv_q;
      miso_d     = drv_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      take_word  = 1'b0;
      load_word  = hold_vld_q ? hold_q : DEFAULT_TX;
      settle_d   = settle_done ? settle_q : settle_q + 1'b1;
      // Frames only start once cs_n has been seen high after reset, so a reset
      // inside a frame ignores the rest of it.
      armed_d    = armed_q | (settle_done & cs_s);

      if (tx_valid && !hold_vld_q) begin
         hold_d     = tx_data;
         hold_vld_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (armed_q && cs_fall) state_d = LOAD;
         end
         LOAD: begin
            take_word = 1'b1;
            cnt_d     = '0;
            rx_sh_d   = '0;
            if (CPHA) begin
               tx_sh_d = load_word;
            end else begin
               drv_d   = load_word[OUT_BIT];
               tx_sh_d = shift_out(load_word);
            end
            state_d = cs_s ? IDLE : ACTIVE;
         end
         ACTIVE: begin
            if (done_q) begin
               rx_data_d  = rx_sh_q;
               rx_valid_d = 1'b1;
               cnt_d      = '0;
               if (cs_s) begin
                  state_d = IDLE;
               end else begin
                  take_word = 1'b1;
                  tx_sh_d   = load_word;
               end
            end else if (cs_s && !(sample_ev && cnt_q == LAST)) begin
               state_d = IDLE;
            end else begin
               if (sample_ev) begin
                  rx_sh_d = shift_in(rx_sh_q, mosi_s);
                  cnt_d   = cnt_q + 1'b1;
                  done_d  = (cnt_q == LAST);
               end
               if (shift_ev) begin
                  drv_d   = tx_sh_q[OUT_BIT];
                  tx_sh_d = shift_out(tx_sh_q);
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if (take_word && hold_vld_q) hold_vld_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         hold_vld_q <= 1'b0;
         tx_sh_q    <= '0;
         rx_sh_q    <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
         drv_q      <= 1'b0;
         miso_q     <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         settle_q   <= '0;
         armed_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         tx_sh_q    <= tx_sh_d;
         rx_sh_q    <= rx_sh_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
         drv_q      <= drv_d;
         miso_q     <= miso_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         settle_q   <= settle_d;
         armed_q    <= armed_d;
      end
   end

   assign miso     = miso_q;
   assign miso_oe  = (state_q != IDLE);
   assign tx_ready = ~hold_vld_q;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign busy     = armed_q & ~cs_s;

endmodule
